// File: rtl/pixel_pkg.sv
// Shared types and default phase lengths for the 2x2 pixel array frame sequencer.
package pixel_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERASE   = 3'd1,
        EXPOSE  = 3'd2,
        CONVERT = 3'd3,
        READ1   = 3'd4,
        READ2   = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam int DEF_ERASE_CYCLES  = 5;
    localparam int DEF_EXPOSE_CYCLES = 255;
    localparam int DEF_READ_CYCLES   = 5;
    localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/pixel_array_fsm.sv
// Frame sequencer: erase, expose, ADC ramp convert, two row reads, then a valid/ready frame hand-off.
// Every output is registered from the next-state decode, so strobes change only on clock edges.
module pixel_array_fsm
    import pixel_pkg::*;
#(
    parameter int ERASE_CYCLES  = DEF_ERASE_CYCLES,
    parameter int EXPOSE_CYCLES = DEF_EXPOSE_CYCLES,
    parameter int READ_CYCLES   = DEF_READ_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               continuous,
    output logic               erase,
    output logic               expose,
    output logic               convert,
    output logic               cnt_oe,
    output logic [CNT_W-1:0]   adc_cnt,
    output logic               read_1,
    output logic               read_2,
    input  logic [2*CNT_W-1:0] data_1_in,
    input  logic [2*CNT_W-1:0] data_2_in,
    output logic [4*CNT_W-1:0] pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               busy
);

    localparam logic [15:0] ERASE_LAST  = 16'(ERASE_CYCLES - 1);
    localparam logic [15:0] EXPOSE_LAST = 16'(EXPOSE_CYCLES - 1);
    localparam logic [15:0] CONV_LAST   = 16'((1 << CNT_W) - 1);
    localparam logic [15:0] READ_LAST   = 16'(READ_CYCLES - 1);

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [4*CNT_W-1:0] pix_data_q, pix_data_d;
    logic [CNT_W-1:0]   adc_cnt_q, adc_cnt_d;
    logic erase_q, erase_d, expose_q, expose_d, convert_q, convert_d, cnt_oe_q, cnt_oe_d;
    logic read_1_q, read_1_d, read_2_q, read_2_d, pix_valid_q, pix_valid_d, busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        pix_data_d = pix_data_q;
        case (state_q)
            IDLE:    if (start) state_d = ERASE;
            ERASE:   if (cnt_q == ERASE_LAST) state_d = EXPOSE;
            EXPOSE:  if (cnt_q == EXPOSE_LAST) state_d = CONVERT;
            CONVERT: if (cnt_q == CONV_LAST) state_d = READ1;
            READ1: begin
                if (cnt_q == READ_LAST) begin
                    state_d = READ2;
                    pix_data_d[2*CNT_W-1:0] = data_1_in;
                end
            end
            READ2: begin
                if (cnt_q == READ_LAST) begin
                    state_d = DONE;
                    pix_data_d[4*CNT_W-1:2*CNT_W] = data_2_in;
                end
            end
            // pix_valid_q is always set while in DONE, so pix_ready alone is the handshake
            DONE:    if (pix_ready) state_d = continuous ? ERASE : IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q || state_q == IDLE || state_q == DONE)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 16'd1;

        erase_d     = (state_d == ERASE);
        expose_d    = (state_d == EXPOSE);
        convert_d   = (state_d == CONVERT);
        cnt_oe_d    = (state_d == CONVERT);
        adc_cnt_d   = (state_d == CONVERT) ? cnt_d[CNT_W-1:0] : '0;
        read_1_d    = (state_d == READ1);
        read_2_d    = (state_d == READ2);
        pix_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pix_data_q  <= '0;
            adc_cnt_q   <= '0;
            erase_q     <= 1'b0;
            expose_q    <= 1'b0;
            convert_q   <= 1'b0;
            cnt_oe_q    <= 1'b0;
            read_1_q    <= 1'b0;
            read_2_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pix_data_q  <= pix_data_d;
            adc_cnt_q   <= adc_cnt_d;
            erase_q     <= erase_d;
            expose_q    <= expose_d;
            convert_q   <= convert_d;
            cnt_oe_q    <= cnt_oe_d;
            read_1_q    <= read_1_d;
            read_2_q    <= read_2_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign erase     = erase_q;
    assign expose    = expose_q;
    assign convert   = convert_q;
    assign cnt_oe    = cnt_oe_q;
    assign adc_cnt   = adc_cnt_q;
    assign read_1    = read_1_q;
    assign read_2    = read_2_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign busy      = busy_q;

endmodule
